// File: rtl/preset_seq_pkg.sv
// preset_seq_pkg: shared state encoding and default sizes for the preset sequencer.
package preset_seq_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP} seq_state_t;
    localparam int DEFAULT_WIDTH = 7;
    localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/preset_fifo.sv
// preset_fifo: small FIFO of preset values; level tells full from empty.
module preset_fifo
    import preset_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end
    assign rd_data = mem[rd_ptr];
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
endmodule

// File: rtl/preset_sequencer.sv
// preset_sequencer: queues presets and launches them one at a time into a countdown,
// tracking its active flag for completion or ack timeout.
module preset_sequencer
    import preset_seq_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_value,
    output logic                   cd_start,
    output logic [WIDTH-1:0]       cd_preset,
    input  logic                   cd_active,
    output logic                   busy,
    output logic                   done_pulse,
    output logic                   err_pulse,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam seq_state_t AFTER_RUN = GAP_CYCLES > 0 ? GAP : IDLE;

    seq_state_t state, state_nx;
    logic [AW-1:0] ack_cnt;
    logic [GW-1:0] gap_cnt;
    logic [WIDTH-1:0] head;
    logic [LW-1:0] level_nx;
    logic push, pop, full, empty, zero_pop, ack_expired, run_done;

    preset_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .wr_data(in_value), .pop(pop),
        .rd_data(head), .level(level), .full(full), .empty(empty)
    );

    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign pop         = state == IDLE && !empty && !cd_active;
    assign zero_pop    = pop && head == '0;
    assign ack_expired = state == WAIT_ACK && !cd_active && ack_cnt == AW'(ACK_TIMEOUT - 1);
    assign run_done    = state == WAIT_DONE && !cd_active;
    assign level_nx    = level + LW'(push) - LW'(pop);

    always_comb begin
        case (state)
            IDLE:      state_nx = !pop ? IDLE : zero_pop ? AFTER_RUN : LAUNCH;
            LAUNCH:    state_nx = WAIT_ACK;
            WAIT_ACK:  state_nx = cd_active ? WAIT_DONE : ack_expired ? AFTER_RUN : WAIT_ACK;
            WAIT_DONE: state_nx = run_done ? AFTER_RUN : WAIT_DONE;
            GAP:       state_nx = gap_cnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
            default:   state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack_cnt    <= '0;
            gap_cnt    <= '0;
            cd_start   <= 1'b0;
            cd_preset  <= '0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            ack_cnt    <= state == WAIT_ACK ? ack_cnt + AW'(1) : '0;
            gap_cnt    <= state == GAP ? gap_cnt + GW'(1) : '0;
            cd_start   <= state_nx == LAUNCH;
            if (pop) cd_preset <= head;
            done_pulse <= zero_pop || run_done;
            err_pulse  <= ack_expired;
            busy       <= state_nx != IDLE || level_nx != '0;
        end
    end
endmodule

// File: tb/tb_preset_sequencer.sv
// tb_preset_sequencer: drives presets and a countdown stand-in, predicting every output
// from a launch schedule computed with plain cycle arithmetic.
module tb_preset_sequencer;
    localparam int W = 7;
    localparam int D = 4;
    localparam int G = 2;
    localparam int A = 8;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, cd_start, cd_active, busy, done_pulse, err_pulse;
    logic [W-1:0] in_value, cd_preset;
    logic [2:0] level;

    int vectors = 0, miscompares = 0, cyc = 0, free_at = 0, run_left = 0, ack_mode = 1;
    bit chk = 0, ack_flag = 0, fg_en = 0, noack_next = 0;
    logic start_prev = 1'b0;
    logic [W-1:0] preset_prev = '0, exp_preset = '0;
    logic [W-1:0] q[$];
    bit exp_start[int], exp_done[int], exp_err[int];

    preset_sequencer #(.WIDTH(W), .DEPTH(D), .GAP_CYCLES(G), .ACK_TIMEOUT(A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .cd_start(cd_start), .cd_preset(cd_preset), .cd_active(cd_active), .busy(busy),
        .done_pulse(done_pulse), .err_pulse(err_pulse), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit v, input int val, input bit r);
        bit push_now, pop_now;
        logic [W-1:0] hv;
        rst = r;
        in_valid = v;
        in_value = W'(val);
        // countdown stand-in: goes active the cycle after start, for preset cycles
        if (start_prev === 1'b1 && ack_flag) run_left = int'(preset_prev);
        cd_active = run_left != 0 || (fg_en && run_left == 0 && cyc >= free_at && $urandom_range(7) == 0);
        if (run_left != 0) run_left--;
        @(negedge clk);
        if (chk) begin
            check("start", 32'(cd_start), 32'(exp_start.exists(cyc)));
            check("preset", 32'(cd_preset), 32'(exp_preset));
            check("done", 32'(done_pulse), 32'(exp_done.exists(cyc)));
            check("err", 32'(err_pulse), 32'(exp_err.exists(cyc)));
            check("busy", 32'(busy), 32'(cyc < free_at || q.size() != 0));
            check("level", 32'(level), 32'(q.size()));
            check("ready", 32'(in_ready), 32'(q.size() < D));
        end
        start_prev = cd_start;
        preset_prev = cd_preset;
        if (r) begin
            q.delete();
            exp_start.delete();
            exp_done.delete();
            exp_err.delete();
            exp_preset = '0;
            free_at = cyc + 1;
            chk = 1;
        end else begin
            push_now = v && q.size() < D;
            pop_now = cyc >= free_at && q.size() != 0 && !cd_active;
            if (pop_now) begin
                hv = q.pop_front();
                exp_preset = hv;
                if (hv == 0) begin
                    exp_done[cyc + 1] = 1;
                    free_at = cyc + 1 + G;
                end else begin
                    exp_start[cyc + 1] = 1;
                    ack_flag = noack_next ? 0 : ack_mode == 1 ? 1 : $urandom_range(4) != 0;
                    noack_next = 0;
                    if (ack_flag) begin
                        exp_done[cyc + 3 + int'(hv)] = 1;
                        free_at = cyc + 3 + int'(hv) + G;
                    end else begin
                        exp_err[cyc + 2 + A] = 1;
                        free_at = cyc + 2 + A + G;
                    end
                end
            end
            if (push_now) q.push_back(W'(val));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int val;
        rst = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        cd_active = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        step(1, 5, 0);
        repeat (14) step(0, 0, 0);
        step(1, 20, 0);
        repeat (3) step(0, 0, 0);
        step(1, 3, 0); step(1, 7, 0); step(1, 1, 0); step(1, 9, 0); step(1, 11, 0);
        repeat (80) step(0, 0, 0);
        step(1, 0, 0); step(1, 4, 0);
        repeat (20) step(0, 0, 0);
        noack_next = 1;
        step(1, 6, 0); step(1, 2, 0);
        repeat (30) step(0, 0, 0);
        step(1, 10, 0); step(1, 1, 0); step(1, 2, 0);
        repeat (4) step(0, 0, 0);
        step(0, 0, 1);
        repeat (15) step(0, 0, 0);
        step(1, 4, 0); step(0, 0, 0); step(1, 1, 0); step(1, 2, 0);
        repeat (6) step(0, 0, 0);
        step(1, 3, 0);
        repeat (25) step(0, 0, 0);
        ack_mode = 0;
        fg_en = 1;
        for (int i = 0; i < 3000; i++) begin
            val = $urandom_range(9) == 0 ? int'($urandom_range(127)) : int'($urandom_range(12));
            step($urandom_range(2) == 0, val, $urandom_range(499) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/preset_sequencer.md
# preset_sequencer

Upstream feeder for the `countdown` stage: accepts preset values through a valid/ready input and buffers them in a small FIFO. It launches them one at a time into `countdown` as a single-cycle `start` pulse with a stable `preset_value`. It then tracks the countdown's `active` output to know when each run finishes, and only launches the next preset after that. Outputs drive `countdown.start`/`countdown.preset_value` directly; `countdown.active` feeds back.

## Interface
- `WIDTH`, 7: preset/count width; matches `countdown` preset width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, 2: idle cycles inserted after each run before the next launch; 0 allowed.
- `ACK_TIMEOUT`, 8: cycles after the start pulse to wait for `cd_active` before declaring an error; ≥1.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  preset offered.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_value`  in  WIDTH  preset value.
- `cd_start`  out  1  one-cycle launch pulse to `countdown.start`.
- `cd_preset`  out  WIDTH  to `countdown.preset_value`; held from pop until the next pop.
- `cd_active`  in  1  from `countdown.active`.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `done_pulse`  out  1  one cycle per completed or skipped preset.
- `err_pulse`  out  1  one cycle on ack timeout.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** a value is pushed when `in_valid && in_ready`.
  - There is no pass-through: a push and a pop in the same cycle are both honoured. `level` is unchanged in that case.
  - A push while full is impossible because `in_ready` is 0.
- **State machine:** IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP.
  - **IDLE:** acts when `level`≠0 and `cd_active`==0. It pops the head into `cd_preset`.
    - If the popped value is 0, it does not launch. It asserts `done_pulse` next cycle and goes to GAP, or to IDLE if `GAP_CYCLES`==0.
    - If the popped value is non-zero, it goes to LAUNCH.
    - If `cd_active`==1 while IDLE (foreign activity), it waits.
  - **LAUNCH:** `cd_start`=1 for exactly this one cycle, then goes to WAIT_ACK. The ack-timeout counter clears.
  - **WAIT_ACK:**
    - If `cd_active`==1, go to WAIT_DONE.
    - Otherwise the counter increments. When it reaches `ACK_TIMEOUT`, assert `err_pulse` and go to GAP. No `done_pulse` is issued.
  - **WAIT_DONE:** on `cd_active`==0, assert `done_pulse` and go to GAP.
  - **GAP:** counts `GAP_CYCLES` cycles, then goes to IDLE. With `GAP_CYCLES`==0, GAP is bypassed: transitions that target GAP go straight to IDLE.
- **Output registers:** all outputs are registered and Moore-decoded from state, except `in_ready`, which is decoded from the `level` register.
- **Reset (mid-run included):** at the next edge, state=IDLE, FIFO empty, `level`=0, `cd_start`=0, `cd_preset`=0, `done_pulse`=0, `err_pulse`=0, `busy`=0, `in_ready`=1, and all counters are 0. An in-flight countdown is not tracked after reset.
- **FIFO pointers:** wrap modulo `DEPTH`. `level` distinguishes full from empty.

## Timing
- **Push-to-start latency:** an empty FIFO and IDLE state, with a push accepted in cycle t, gives:
  - t+1: the pop;
  - t+2: `cd_start` high for one cycle with `cd_preset` valid; `cd_preset` is already valid from t+2.
- **Preset stability:** `cd_preset` is stable from the pop cycle+1 until at least the cycle after `cd_start` falls.
- **`done_pulse` timing:** high in the cycle after the first `cd_active`==0 sample in WAIT_DONE.
- **Back-to-back launches:** the minimum spacing between `cd_start` pulses is the run length + 3 + `GAP_CYCLES`.
- **`level` update:** updates one cycle after the push/pop edge.

## Structure
- **Package `preset_seq_pkg`:** `seq_state_t` enum (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP), plus default-width and default-depth localparams shared with the bench.
- **Sub-module `preset_fifo`:** parameterised by `WIDTH`/`DEPTH`. Provides push/pop, `rd_data`, `level`, `full`, and `empty`. The top level holds the FSM, the gap/timeout counters and the output registers.

## Test plan
- **Single preset:** after reset, push 5 against a behavioural countdown model. Required: `cd_start` is high exactly 2 cycles after the push with `cd_preset`=5, then one `done_pulse` after `cd_active` falls, then `busy`=0.
- **Full FIFO:** push 3, 7, 1, 9 in consecutive cycles (`DEPTH`=4). Required: `in_ready`=0 after the 4th push, and launches occur in order 3, 7, 1, 9, each separated by ≥`GAP_CYCLES` idle cycles with `cd_active` low.
- **Zero preset:** push 0 then 4. Required: no `cd_start` for the 0, one `done_pulse` for it, then a normal launch with 4.
- **Ack timeout:** hold `cd_active`=0 after a launch. Required: `err_pulse` exactly `ACK_TIMEOUT`(=8) cycles after WAIT_ACK entry, no `done_pulse`, and the next queued value launches afterward.
- **Mid-run reset:** assert `rst` for one cycle during WAIT_DONE with 2 entries queued. Required: next cycle `level`=0, `cd_start`=0, `cd_preset`=0, `busy`=0, `in_ready`=1.
- **Simultaneous push and pop:** push at the same edge as an IDLE pop with `level`=2. Required: `level` stays 2 and the order is preserved.
